// File: rtl/hm01b0_block_ingest_if.sv
// hm01b0_block_ingest_if: camera pixel bus in, 8x8 block-ordered pixel stream out.
interface hm01b0_block_ingest_if;
    logic [7:0] pixdata;
    logic       hsync;
    logic       vsync;
    logic [7:0] out_pixel;
    logic       out_valid;
    logic       out_ready;
    logic       out_block_first;
    logic       out_frame_last;
    logic       overflow;
    modport master (
        output pixdata, hsync, vsync, out_ready,
        input  out_pixel, out_valid, out_block_first, out_frame_last, overflow
    );
    modport slave (
        input  pixdata, hsync, vsync, out_ready,
        output out_pixel, out_valid, out_block_first, out_frame_last, overflow
    );
endinterface

// File: rtl/hm01b0_block_ingest.sv
// hm01b0_block_ingest: buffers 8-line stripes ping-pong and replays them as 8x8 blocks.
module hm01b0_block_ingest #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
) (
    input logic clock,
    input logic reset,
    hm01b0_block_ingest_if.slave bus
);
    localparam int STRIPES = HEIGHT / 8;
    localparam int SBYTES  = 8 * WIDTH;
    localparam int AW      = $clog2(2 * SBYTES);
    localparam int CW      = $clog2(WIDTH + 1);
    localparam int BW      = (WIDTH / 8 > 1) ? $clog2(WIDTH / 8) : 1;
    localparam int SW      = (STRIPES > 1) ? $clog2(STRIPES) : 1;
    typedef enum logic {IDLE, STREAM} state_t;

    logic [7:0]    mem [2*SBYTES];
    logic          hs_q, vs_q, armed, drop, wsel, rsel;
    logic [1:0]    full, last;
    logic [CW-1:0] col;
    logic [2:0]    line;
    logic [SW-1:0] stripe_idx;
    logic          frame_start, line_end, px_in, drop_now, we, wrap, set_full, clr_full;
    logic [AW-1:0] waddr, raddr;
    state_t        state, state_nx;
    logic [BW-1:0] bx;
    logic [2:0]    r, c;
    logic          issued, ren, done, last_issue, stripe_end;

    // armed stays low after reset until vsync is seen low, so a frame already in flight is ignored
    always_comb begin
        frame_start = armed && bus.vsync && !vs_q;
        px_in       = armed && !frame_start && bus.hsync && bus.vsync;
        drop_now    = px_in && !drop && line == 3'd0 && col == '0 && full[wsel];
        we          = px_in && !drop && !drop_now && col < CW'(WIDTH);
        line_end    = armed && !frame_start && !bus.hsync && hs_q && bus.vsync;
        wrap        = line_end && line == 3'd7;
        set_full    = wrap && !drop;
        waddr       = AW'(int'(wsel) * SBYTES + int'(line) * WIDTH + int'(col));
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            armed        <= 1'b0;
            col          <= '0;
            line         <= '0;
            stripe_idx   <= '0;
            drop         <= 1'b0;
            wsel         <= 1'b0;
            last         <= '0;
            bus.overflow <= 1'b0;
        end else begin
            hs_q <= bus.hsync;
            vs_q <= bus.vsync;
            if (!bus.vsync) armed <= 1'b1;
            if (frame_start) begin
                col        <= '0;
                line       <= '0;
                stripe_idx <= '0;
                drop       <= 1'b0;
            end else if (line_end) begin
                col  <= '0;
                line <= line + 3'd1;
                if (wrap) begin
                    stripe_idx <= stripe_idx + SW'(1);
                    drop       <= 1'b0;
                    if (!drop) begin
                        last[wsel] <= stripe_idx == SW'(STRIPES - 1);
                        wsel       <= !wsel;
                    end
                end
            end else begin
                if (drop_now) begin
                    drop         <= 1'b1;
                    bus.overflow <= 1'b1;
                end
                if (we) col <= col + CW'(1);
            end
        end

    // writer sets and reader clears always hit different stripes, so both apply
    always_ff @(posedge clock or posedge reset)
        if (reset) full <= '0;
        else full <= (full | ({1'b0, set_full} << wsel)) & ~({1'b0, clr_full} << rsel);

    always_ff @(posedge clock)
        if (we) mem[waddr] <= bus.pixdata;

    always_ff @(posedge clock or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nx;

    always_comb
        state_nx = state == IDLE ? (full[rsel] ? STREAM : IDLE) : (done ? IDLE : STREAM);

    always_comb begin
        ren        = state == STREAM && !issued && (!bus.out_valid || bus.out_ready);
        done       = state == STREAM && bus.out_valid && bus.out_ready && stripe_end;
        clr_full   = done;
        last_issue = bx == BW'(WIDTH / 8 - 1) && r == 3'd7 && c == 3'd7;
        raddr      = AW'(int'(rsel) * SBYTES + int'(r) * WIDTH + int'(bx) * 8 + int'(c));
    end

    // the RAM read register doubles as the output register, so a stall simply withholds the read
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            bx                  <= '0;
            r                   <= '0;
            c                   <= '0;
            issued              <= 1'b0;
            rsel                <= 1'b0;
            stripe_end          <= 1'b0;
            bus.out_pixel       <= '0;
            bus.out_valid       <= 1'b0;
            bus.out_block_first <= 1'b0;
            bus.out_frame_last  <= 1'b0;
        end else begin
            if (ren) begin
                bus.out_pixel       <= mem[raddr];
                bus.out_block_first <= r == 3'd0 && c == 3'd0;
                bus.out_frame_last  <= last_issue && last[rsel];
                stripe_end          <= last_issue;
                issued              <= last_issue;
                c                   <= c + 3'd1;
                if (c == 3'd7) begin
                    r <= r + 3'd1;
                    if (r == 3'd7) bx <= last_issue ? '0 : bx + BW'(1);
                end
            end
            if (ren) bus.out_valid <= 1'b1;
            else if (bus.out_ready) bus.out_valid <= 1'b0;
            if (done) begin
                issued <= 1'b0;
                rsel   <= !rsel;
            end
        end
endmodule

// File: doc/hm01b0_block_ingest.md
Name: hm01b0_block_ingest

Overview:
- Consumes the HM01B0 camera pixel stream (pixdata/hsync/vsync) and reorders it into 8x8 pixel blocks for the JPEG pipeline.
- Buffers two 8-line stripes in ping-pong fashion.
- Emits pixels over a valid/ready stream in block order: block, then row, then column.
- Sits between the camera interface and the first JPEG transform stage; detects and flags upstream overrun.

Parameters:
- WIDTH, 320, active pixels per line; must be a multiple of 8.
- HEIGHT, 240, active lines per frame; must be a multiple of 8.

Ports:
- clock  in  1  pixel clock, shared with the camera.
- reset  in  1  asynchronous active-high reset.
- pixdata  in  8  camera pixel; don't-care when hsync or vsync is low.
- hsync  in  1  high while the line's active pixels are presented.
- vsync  in  1  high for the whole active frame.
- out_pixel  out  8  reordered pixel.
- out_valid  out  1  out_pixel is valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_block_first  out  1  qualifies pixel (0,0) of an 8x8 block.
- out_frame_last  out  1  qualifies the final pixel of the final stripe of a frame.
- overflow  out  1  sticky; set when a stripe is dropped; cleared only by reset.

Behaviour:
- Reset: asynchronous, active-high. While asserted:
  - out_valid, out_block_first, out_frame_last, overflow = 0; out_pixel = 0.
  - Both stripe-full flags cleared; write and read selects = stripe 0.
  - All counters = 0; hsync/vsync edge registers = 0.
- Buffer: 2 stripes x 8 lines x WIDTH bytes. Synchronous-read RAM, 1-cycle read latency.
- Writer, edge detection: uses registered copies of hsync and vsync.
- Writer, pixel write: on each clock with hsync && vsync && col < WIDTH && !drop, write pixdata to stripe[wsel], address line*WIDTH+col, then col++. Pixels at col >= WIDTH are ignored (col saturates).
- Writer, end of line: a falling edge of hsync while vsync is high sets col=0 and line++.
  - When line wraps 7->0 with !drop: set full[wsel], record last[wsel] = (stripe_idx == HEIGHT/8-1), toggle wsel.
  - When line wraps 7->0 with drop: clear drop; no full set, no toggle.
  - On any 7->0 wrap, stripe_idx++.
- Writer, stripe start: on the first pixel of a stripe (line==0, col==0), if full[wsel] is set, latch drop=1 and set overflow. The whole stripe is discarded.
- Writer, short lines: lines shorter than WIDTH still count as a line; unwritten bytes hold stale data.
- Writer, frame start: a rising edge of vsync zeroes col, line, stripe_idx and drop. Any partial stripe is discarded. Full flags and reader state are untouched.
- Reader FSM, IDLE: wait for full[rsel], then go to STREAM.
- Reader FSM, STREAM: iterate bx 0..WIDTH/8-1, row r 0..7, col c 0..7. Read address = r*WIDTH + bx*8 + c.
- Reader FSM, stripe done: when the last pixel of the stripe is accepted, clear full[rsel], toggle rsel, return to IDLE.
- Reader timing:
  - First out_valid no later than 2 cycles after full[rsel] rises.
  - With out_ready held high, throughput is 1 pixel/cycle with no bubbles inside a stripe.
- Output hold: while out_valid && !out_ready, out_pixel, out_block_first and out_frame_last are held stable.
- Output flags: out_block_first is high when r==0 && c==0. out_frame_last is high on the last pixel of a stripe whose last flag is set.
- Simultaneous events: if the writer checks full[wsel] in the same cycle the reader clears it, the writer sees the old value (full) and drops the stripe. Writer set and reader clear of different stripes in the same cycle both take effect.
- Reset mid-operation: all state is abandoned immediately. The first stripe after reset deasserts begins at the next vsync rising edge.

Test Plan:
1. Frame at WIDTH=16, HEIGHT=16, pixel=(y*16+x)&0xFF, out_ready=1.
   - Outputs begin 0,1..7,16..23,...,112..119, then 8..15,24..31,...
   - 256 pixels total.
   - out_block_first on pixel indices 0,64,128,192.
   - out_frame_last only on index 255.
   - overflow=0.
2. Same frame with out_ready toggled pseudo-randomly.
   - Identical accepted sequence; no loss or duplication.
   - Outputs stable while valid && !ready.
3. WIDTH=16, HEIGHT=24, out_ready=0 for the whole frame.
   - Stripes 0 and 1 buffered; stripe 2 dropped; overflow=1.
   - After releasing ready: 256 pixels of lines 0-15 are emitted, with no out_frame_last.
4. vsync rises again after 5 lines of a frame, then a full frame follows.
   - Partial stripe discarded.
   - Output equals case 1 for the new frame.
5. Lines with WIDTH+4 hsync-high cycles and 20-cycle hsync-low padding.
   - Extra pixels ignored.
   - Output identical to case 1.
6. reset pulsed mid-stream, then a full frame.
   - out_valid=0 and overflow=0 while reset is high.
   - Next frame output matches case 1.
